mask_share_encoder: RTL and testbench

- Converts an unmasked WIDTH-bit word into a 2-share Boolean encoding (s0 ^ s1 = data) for our first-order masked gadgets.
- Also delivers NRAND fresh refresh bits per word, so a downstream gadget receives its shares and its randomness in one transaction.
- Randomness is gathered from an external RNG over a narrow valid/ready stream, so one word takes several beats; a small FSM sequences this.
- Sits between the unmasked input datapath and the masked gadget array.

---
 rtl/mask_share_encoder_if.sv | 31 +++
 rtl/mask_share_encoder.sv | 102 ++++++++++
 tb/tb_mask_share_encoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mask_share_encoder_if.sv
// Stream bundle for the share encoder: plaintext in, RNG beats in, shares plus refresh bits out.
interface mask_share_encoder_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NRAND = 3,
    parameter int unsigned RNG_W = 4
);
    // A zero-width refresh field is carried as one bit that stays 0
    localparam int unsigned NRAND_W = (NRAND > 0) ? NRAND : 1;

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               rng_valid;
    logic               rng_ready;
    logic [RNG_W-1:0]   rng_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_s0;
    logic [WIDTH-1:0]   out_s1;
    logic [NRAND_W-1:0] out_rand;

    modport master (
        output in_valid, in_data, rng_valid, rng_data, out_ready,
        input  in_ready, rng_ready, out_valid, out_s0, out_s1, out_rand
    );

    modport slave (
        input  in_valid, in_data, rng_valid, rng_data, out_ready,
        output in_ready, rng_ready, out_valid, out_s0, out_s1, out_rand
    );
endinterface

// File: rtl/mask_share_encoder.sv
// Splits a plaintext word into two Boolean shares using RNG beats gathered over a narrow stream,
// and forwards leftover fresh bits as refresh randomness. All outputs are registered.
module mask_share_encoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NRAND = 3,
    parameter int unsigned RNG_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    mask_share_encoder_if.slave  bus
);
    localparam int unsigned TOTAL   = WIDTH + NRAND;
    localparam int unsigned BEATS   = (TOTAL + RNG_W - 1) / RNG_W;
    localparam int unsigned CNT_W   = $clog2(BEATS + 1);
    localparam int unsigned NRAND_W = (NRAND > 0) ? NRAND : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATHER,
        ST_OUT
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   data;
    logic [TOTAL-1:0]   pool;
    logic [CNT_W-1:0]   cnt;

    logic [TOTAL-1:0]   pool_next;
    logic [WIDTH-1:0]   mask_next;
    logic [NRAND_W-1:0] rand_next;
    logic               last_beat;

    // Only pool bits below TOTAL exist, so excess bits of the final beat are simply never stored
    always_comb begin
        pool_next = pool;
        for (int unsigned i = 0; i < TOTAL; i++) begin
            if ((i / RNG_W) == 32'(cnt))
                pool_next[i] = bus.rng_data[i % RNG_W];
        end
        mask_next = pool_next[WIDTH-1:0];
        rand_next = '0;
        for (int unsigned i = 0; i < NRAND; i++)
            rand_next[i] = pool_next[WIDTH+i];
        last_beat = (cnt == CNT_W'(BEATS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            data          <= '0;
            pool          <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.rng_ready <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_s0    <= '0;
            bus.out_s1    <= '0;
            bus.out_rand  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data          <= bus.in_data;
                        cnt           <= '0;
                        bus.in_ready  <= 1'b0;
                        bus.rng_ready <= 1'b1;
                        state         <= ST_GATHER;
                    end
                end
                ST_GATHER: begin
                    if (bus.rng_valid) begin
                        pool <= pool_next;
                        cnt  <= cnt + 1'b1;
                        if (last_beat) begin
                            // Plaintext is dropped the moment it has been masked
                            bus.out_s0    <= data ^ mask_next;
                            bus.out_s1    <= mask_next;
                            bus.out_rand  <= rand_next;
                            data          <= '0;
                            bus.rng_ready <= 1'b0;
                            bus.out_valid <= 1'b1;
                            state         <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_s0    <= '0;
                        bus.out_s1    <= '0;
                        bus.out_rand  <= '0;
                        pool          <= '0;
                        cnt           <= '0;
                        bus.in_ready  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mask_share_encoder.sv
// Directed bench for mask_share_encoder: default build (BEATS=3) plus a WIDTH=4/NRAND=0 build.
module tb_mask_share_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    mask_share_encoder_if #(.WIDTH(8), .NRAND(3), .RNG_W(4)) bus ();
    mask_share_encoder_if #(.WIDTH(4), .NRAND(0), .RNG_W(4)) bus2 ();

    mask_share_encoder #(.WIDTH(8), .NRAND(3), .RNG_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mask_share_encoder #(.WIDTH(4), .NRAND(0), .RNG_W(4)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] b);
        bus.rng_valid = 1'b1;
        bus.rng_data  = b;
        step();
        bus.rng_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [2:0] r);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_s0"}, 32'(bus.out_s0), 32'(s0));
        check({tag, "_s1"}, 32'(bus.out_s1), 32'(s1));
        check({tag, "_rand"}, 32'(bus.out_rand), 32'(r));
    endtask

    task automatic accept(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_done_s0"}, 32'(bus.out_s0), 32'd0);
        check({tag, "_done_s1"}, 32'(bus.out_s1), 32'd0);
        check({tag, "_done_rand"}, 32'(bus.out_rand), 32'd0);
        check({tag, "_done_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.rng_valid = 1'b0;
        bus.rng_data  = '0;
        bus.out_ready = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.rng_valid = 1'b0;
        bus2.rng_data  = '0;
        bus2.out_ready = 1'b0;

        repeat (3) step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_rng_ready", 32'(bus.rng_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_s0", 32'(bus.out_s0), 32'd0);
        check("rst_s1", 32'(bus.out_s1), 32'd0);
        check("rst_rand", 32'(bus.out_rand), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // 1: basic encode, mask 0xC3, bit 3 of the last beat discarded
        send_word(8'hA5);
        check("t1_in_ready", 32'(bus.in_ready), 32'd0);
        check("t1_rng_ready", 32'(bus.rng_ready), 32'd1);
        send_beat(4'h3);
        send_beat(4'hC);
        check("t1_early_valid", 32'(bus.out_valid), 32'd0);
        send_beat(4'h5);
        expect_out("t1", 8'h66, 8'hC3, 3'b101);
        accept("t1");

        // 2: two idle RNG cycles between beats
        send_word(8'hA5);
        send_beat(4'h3);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t2_stall_rng_ready", 32'(bus.rng_ready), 32'd1);
            check("t2_stall_valid", 32'(bus.out_valid), 32'd0);
        end
        send_beat(4'hC);
        check("t2_early_valid", 32'(bus.out_valid), 32'd0);
        send_beat(4'h5);
        expect_out("t2", 8'h66, 8'hC3, 3'b101);
        accept("t2");

        // 3: output backpressure with pressure on both input streams
        send_word(8'hA5);
        send_beat(4'h3);
        send_beat(4'hC);
        send_beat(4'h5);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5A;
        bus.rng_valid = 1'b1;
        bus.rng_data  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("t3_hold", 8'h66, 8'hC3, 3'b101);
            check("t3_in_ready", 32'(bus.in_ready), 32'd0);
            check("t3_rng_ready", 32'(bus.rng_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.rng_valid = 1'b0;
        accept("t3");

        // 4: back-to-back words
        send_word(8'hFF);
        send_beat(4'h0);
        send_beat(4'h0);
        send_beat(4'h0);
        expect_out("t4a", 8'hFF, 8'h00, 3'b000);
        check("t4a_xor", 32'(bus.out_s0 ^ bus.out_s1), 32'hFF);
        accept("t4a");
        send_word(8'h00);
        send_beat(4'hF);
        send_beat(4'hF);
        send_beat(4'h7);
        expect_out("t4b", 8'hFF, 8'hFF, 3'b111);
        check("t4b_xor", 32'(bus.out_s0 ^ bus.out_s1), 32'h00);
        accept("t4b");

        // 5: async reset after one beat, then a fresh word
        send_word(8'h77);
        send_beat(4'h9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_rng_ready", 32'(bus.rng_ready), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_s0", 32'(bus.out_s0), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t5_rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5_rel_valid", 32'(bus.out_valid), 32'd0);
        send_word(8'h12);
        send_beat(4'h1);
        send_beat(4'h0);
        send_beat(4'h0);
        expect_out("t5", 8'h13, 8'h01, 3'b000);
        accept("t5");

        // 6: single-beat variant, WIDTH=4, NRAND=0
        check("t6_in_ready", 32'(bus2.in_ready), 32'd1);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 4'h9;
        step();
        bus2.in_valid = 1'b0;
        check("t6_rng_ready", 32'(bus2.rng_ready), 32'd1);
        check("t6_early_valid", 32'(bus2.out_valid), 32'd0);
        bus2.rng_valid = 1'b1;
        bus2.rng_data  = 4'h6;
        step();
        bus2.rng_valid = 1'b0;
        check("t6_valid", 32'(bus2.out_valid), 32'd1);
        check("t6_s0", 32'(bus2.out_s0), 32'hF);
        check("t6_s1", 32'(bus2.out_s1), 32'h6);
        check("t6_rand", 32'(bus2.out_rand), 32'd0);
        bus2.out_ready = 1'b1;
        step();
        bus2.out_ready = 1'b0;
        check("t6_done_valid", 32'(bus2.out_valid), 32'd0);
        check("t6_done_s0", 32'(bus2.out_s0), 32'd0);
        check("t6_done_in_ready", 32'(bus2.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
